// File: rtl/hazard_if.sv
// Bundle between the ID-stage pipeline control and the hazard unit.
interface hazard_if #(
   parameter int unsigned AW    = 5,
   parameter int unsigned CNT_W = 32
);
   logic [AW-1:0]    id_rs;
   logic [AW-1:0]    id_rt;
   logic             id_rs_used;
   logic             id_rt_used;
   logic             id_hilo_use;
   logic             id_md_op;
   logic             exe_wen;
   logic             mem_wen;
   logic             wb_wen;
   logic [AW-1:0]    exe_wnum;
   logic [AW-1:0]    mem_wnum;
   logic [AW-1:0]    wb_wnum;
   logic             exe_is_load;
   logic             md_start;
   logic [1:0]       rs_sel;
   logic [1:0]       rt_sel;
   logic             stall_id;
   logic             bubble_ex;
   logic             md_busy;
   logic [CNT_W-1:0] stall_cnt;

   // Pipeline side: supplies stage state, consumes hazard controls.
   modport master (
      output id_rs, id_rt, id_rs_used, id_rt_used, id_hilo_use, id_md_op,
             exe_wen, mem_wen, wb_wen, exe_wnum, mem_wnum, wb_wnum,
             exe_is_load, md_start,
      input  rs_sel, rt_sel, stall_id, bubble_ex, md_busy, stall_cnt
   );

   // Hazard unit side.
   modport slave (
      input  id_rs, id_rt, id_rs_used, id_rt_used, id_hilo_use, id_md_op,
             exe_wen, mem_wen, wb_wen, exe_wnum, mem_wnum, wb_wnum,
             exe_is_load, md_start,
      output rs_sel, rt_sel, stall_id, bubble_ex, md_busy, stall_cnt
   );
endinterface

// File: rtl/hazard_unit.sv
// Hazard unit for the 5-stage MIPS core: operand forwarding selects,
// load-use and mult/div stalls, and a saturating stall-cycle counter.
module hazard_unit #(
   parameter int unsigned AW         = 5,
   parameter int unsigned MD_LATENCY = 32,
   parameter int unsigned CNT_W      = 32
) (
   input logic     clk,
   input logic     rst,
   hazard_if.slave bus
);
   localparam int unsigned MD_W = $clog2(MD_LATENCY + 1);

   logic [MD_W-1:0]  md_cnt;
   logic [CNT_W-1:0] stall_cnt;
   logic             md_busy;
   logic             lu;
   logic             mds;
   logic             stall;
   logic [1:0]       rs_sel;
   logic [1:0]       rt_sel;

   // Priority select: youngest producer (EXE) wins; r0 is never forwarded.
   function automatic logic [1:0] fwd_sel(
      input logic [AW-1:0] src,
      input logic          e_wen, input logic [AW-1:0] e_num,
      input logic          m_wen, input logic [AW-1:0] m_num,
      input logic          w_wen, input logic [AW-1:0] w_num
   );
      logic nz;
      nz = (src != '0);
      if (e_wen && nz && (src == e_num))      fwd_sel = 2'b01;
      else if (m_wen && nz && (src == m_num)) fwd_sel = 2'b10;
      else if (w_wen && nz && (src == w_num)) fwd_sel = 2'b11;
      else                                    fwd_sel = 2'b00;
   endfunction

   // Forwarding selects and stall detection, same cycle as the inputs.
   always_comb begin
      rs_sel = fwd_sel(bus.id_rs, bus.exe_wen, bus.exe_wnum,
                       bus.mem_wen, bus.mem_wnum, bus.wb_wen, bus.wb_wnum);
      rt_sel = fwd_sel(bus.id_rt, bus.exe_wen, bus.exe_wnum,
                       bus.mem_wen, bus.mem_wnum, bus.wb_wen, bus.wb_wnum);
      lu = bus.exe_wen && bus.exe_is_load && (bus.exe_wnum != '0) &&
           ((bus.id_rs_used && (bus.id_rs == bus.exe_wnum)) ||
            (bus.id_rt_used && (bus.id_rt == bus.exe_wnum)));
      mds   = md_busy && (bus.id_hilo_use || bus.id_md_op);
      stall = lu || mds;
   end

   assign md_busy = (md_cnt != '0);

   // Mult/div occupancy countdown; a launch while busy is ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         md_cnt <= '0;
      end else if (bus.md_start && !md_busy) begin
         md_cnt <= MD_W'(MD_LATENCY);
      end else if (md_busy) begin
         md_cnt <= md_cnt - MD_W'(1);
      end
   end

   // Stall-cycle counter, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   assign bus.rs_sel    = rs_sel;
   assign bus.rt_sel    = rt_sel;
   assign bus.stall_id  = stall;
   assign bus.bubble_ex = stall;
   assign bus.md_busy   = md_busy;
   assign bus.stall_cnt = stall_cnt;
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: forwarding/load-use vector table plus
// sequences for mult/div busy, reset mid-op and counter saturation.
module tb_hazard_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   hazard_if #(.AW(5), .CNT_W(3)) if0 ();
   hazard_if #(.AW(5), .CNT_W(3)) if1 ();

   hazard_unit #(.AW(5), .MD_LATENCY(4), .CNT_W(3)) dut0 (
      .clk(clk), .rst(rst), .bus(if0)
   );
   hazard_unit #(.AW(5), .MD_LATENCY(1), .CNT_W(3)) dut1 (
      .clk(clk), .rst(rst), .bus(if1)
   );

   // Latency-1 instance only sees the mult/div launch and the HI/LO use.
   assign if1.id_rs       = '0;
   assign if1.id_rt       = '0;
   assign if1.id_rs_used  = 1'b0;
   assign if1.id_rt_used  = 1'b0;
   assign if1.id_hilo_use = if0.id_hilo_use;
   assign if1.id_md_op    = 1'b0;
   assign if1.exe_wen     = 1'b0;
   assign if1.mem_wen     = 1'b0;
   assign if1.wb_wen      = 1'b0;
   assign if1.exe_wnum    = '0;
   assign if1.mem_wnum    = '0;
   assign if1.wb_wnum     = '0;
   assign if1.exe_is_load = 1'b0;
   assign if1.md_start    = if0.md_start;

   typedef struct packed {
      logic [4:0] rs, rt;
      logic       rs_used, rt_used, hilo, md_op;
      logic       exe_wen, mem_wen, wb_wen;
      logic [4:0] exe_wnum, mem_wnum, wb_wnum;
      logic       is_load;
      logic [1:0] exp_rs, exp_rt;
      logic       exp_stall;
   } vec_t;

   vec_t vt [10];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      if0.id_rs = '0; if0.id_rt = '0;
      if0.id_rs_used = 1'b0; if0.id_rt_used = 1'b0;
      if0.id_hilo_use = 1'b0; if0.id_md_op = 1'b0;
      if0.exe_wen = 1'b0; if0.mem_wen = 1'b0; if0.wb_wen = 1'b0;
      if0.exe_wnum = '0; if0.mem_wnum = '0; if0.wb_wnum = '0;
      if0.exe_is_load = 1'b0; if0.md_start = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step();
      rst = 1'b1;
      idle();
      step();
      rst = 1'b0;
   endtask

   task automatic drive_lu_rt8();
      if0.exe_wen = 1'b1; if0.exe_is_load = 1'b1; if0.exe_wnum = 5'd8;
      if0.id_rt = 5'd8; if0.id_rt_used = 1'b1;
   endtask

   initial begin
      //        rs    rt    rsu  rtu  hilo mdop ew   mw   ww   ewn   mwn   wwn   ld   ers    ert    est
      vt[0] = '{5'd5, 5'd0, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,5'd5, 5'd5, 5'd5, 1'b0,2'b01, 2'b00, 1'b0};
      vt[1] = '{5'd5, 5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,5'd5, 5'd5, 5'd5, 1'b0,2'b10, 2'b00, 1'b0};
      vt[2] = '{5'd5, 5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,5'd5, 5'd5, 5'd5, 1'b0,2'b11, 2'b00, 1'b0};
      vt[3] = '{5'd5, 5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd5, 5'd5, 5'd5, 1'b0,2'b00, 2'b00, 1'b0};
      vt[4] = '{5'd0, 5'd0, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b1,2'b00, 2'b00, 1'b0};
      vt[5] = '{5'd3, 5'd7, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,5'd3, 5'd7, 5'd7, 1'b0,2'b01, 2'b10, 1'b0};
      vt[6] = '{5'd9, 5'd1, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,5'd9, 5'd0, 5'd0, 1'b1,2'b01, 2'b00, 1'b1};
      vt[7] = '{5'd9, 5'd1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,5'd9, 5'd0, 5'd0, 1'b1,2'b01, 2'b00, 1'b0};
      vt[8] = '{5'd2, 5'd8, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,5'd8, 5'd0, 5'd2, 1'b1,2'b11, 2'b01, 1'b0};
      vt[9] = '{5'd4, 5'd6, 1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,5'd0, 5'd6, 5'd0, 1'b0,2'b00, 2'b10, 1'b0};

      idle();
      // Reset state with idle inputs.
      step();
      #2;
      chk("reset rs_sel", int'(if0.rs_sel), 0);
      chk("reset rt_sel", int'(if0.rt_sel), 0);
      chk("reset stall_id", int'(if0.stall_id), 0);
      chk("reset md_busy", int'(if0.md_busy), 0);
      chk("reset stall_cnt", int'(if0.stall_cnt), 0);
      rst = 1'b0;

      // Combinational vector table.
      for (int i = 0; i < 10; i++) begin
         step();
         if0.id_rs = vt[i].rs; if0.id_rt = vt[i].rt;
         if0.id_rs_used = vt[i].rs_used; if0.id_rt_used = vt[i].rt_used;
         if0.id_hilo_use = vt[i].hilo; if0.id_md_op = vt[i].md_op;
         if0.exe_wen = vt[i].exe_wen; if0.mem_wen = vt[i].mem_wen;
         if0.wb_wen = vt[i].wb_wen; if0.exe_wnum = vt[i].exe_wnum;
         if0.mem_wnum = vt[i].mem_wnum; if0.wb_wnum = vt[i].wb_wnum;
         if0.exe_is_load = vt[i].is_load;
         #2;
         chk($sformatf("vec%0d rs_sel", i), int'(if0.rs_sel), int'(vt[i].exp_rs));
         chk($sformatf("vec%0d rt_sel", i), int'(if0.rt_sel), int'(vt[i].exp_rt));
         chk($sformatf("vec%0d stall_id", i), int'(if0.stall_id), int'(vt[i].exp_stall));
         chk($sformatf("vec%0d bubble_ex", i), int'(if0.bubble_ex), int'(vt[i].exp_stall));
      end

      // Load-use: one stall, then the load sits in MEM and forwards.
      do_reset();
      drive_lu_rt8();
      #2;
      chk("lu stall_id", int'(if0.stall_id), 1);
      chk("lu bubble_ex", int'(if0.bubble_ex), 1);
      step();
      if0.exe_wen = 1'b0; if0.exe_is_load = 1'b0; if0.exe_wnum = '0;
      if0.mem_wen = 1'b1; if0.mem_wnum = 5'd8;
      #2;
      chk("lu next stall_id", int'(if0.stall_id), 0);
      chk("lu next rt_sel", int'(if0.rt_sel), 2);
      chk("lu stall_cnt", int'(if0.stall_cnt), 1);
      step();
      idle();
      drive_lu_rt8();
      if0.id_rt_used = 1'b0;
      #2;
      chk("lu unused stall_id", int'(if0.stall_id), 0);

      // Mult/div busy window, ignored relaunch, overlapping load-use.
      do_reset();
      if0.md_start = 1'b1; if0.id_hilo_use = 1'b1;
      #2;
      chk("md t stall_id", int'(if0.stall_id), 0);
      chk("md t md_busy", int'(if0.md_busy), 0);
      for (int k = 1; k <= 5; k++) begin
         step();
         idle();
         if0.id_hilo_use = 1'b1;
         if0.md_start = (k == 2);
         if (k == 3) drive_lu_rt8();
         #2;
         chk($sformatf("md k%0d md_busy", k), int'(if0.md_busy), int'(k <= 4));
         chk($sformatf("md k%0d stall_id", k), int'(if0.stall_id), int'(k <= 4));
         chk($sformatf("md1 k%0d md_busy", k), int'(if1.md_busy), int'(k == 1 || k == 3));
      end
      chk("md stall_cnt", int'(if0.stall_cnt), 4);
      chk("md1 stall_cnt", int'(if1.stall_cnt), 2);

      // Reset in the middle of a mult/div.
      do_reset();
      if0.md_start = 1'b1; if0.id_hilo_use = 1'b1;
      step();
      if0.md_start = 1'b0;
      #2;
      chk("rstmid c1 md_busy", int'(if0.md_busy), 1);
      step();
      rst = 1'b1;
      #2;
      chk("rstmid c2 stall_cnt", int'(if0.stall_cnt), 1);
      step();
      rst = 1'b0;
      #2;
      chk("rstmid c3 md_busy", int'(if0.md_busy), 0);
      chk("rstmid c3 stall_cnt", int'(if0.stall_cnt), 0);
      chk("rstmid c3 stall_id", int'(if0.stall_id), 0);

      // Saturation of the 3-bit stall counter.
      do_reset();
      drive_lu_rt8();
      for (int i = 1; i <= 10; i++) begin
         step();
         #2;
         chk($sformatf("sat c%0d stall_cnt", i), int'(if0.stall_cnt), (i < 7) ? i : 7);
      end
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
